exp_reg_bank: RTL and testbench

EXP_REG_BANK -- requirements
Module: exp_reg_bank

---
 rtl/exp_reg_bank_pkg.sv | 27 ++
 rtl/exp_reg_bank_if.sv | 36 +++
 rtl/exp_reg_read_port.sv | 36 +++
 rtl/exp_reg_bank.sv | 97 +++++++++
 tb/tb_exp_reg_bank.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/exp_reg_bank_pkg.sv
// Shared definitions for the exponent register bank: select-map bases and the
// default read-only constant table.
package exp_reg_bank_pkg;

    localparam int unsigned DEF_REGISTER_WIDTH = 9;
    localparam int unsigned DEF_NUM_GPR        = 4;
    localparam int unsigned DEF_NUM_CONST      = 6;
    localparam int unsigned DEF_SEL_WIDTH      = 4;

    // GPRs start at select 0; constants follow directly after the last GPR
    localparam int unsigned GPR_SEL_BASE = 0;

    localparam logic [DEF_REGISTER_WIDTH-1:0] CONST_ZERO     = 9'd0;
    localparam logic [DEF_REGISTER_WIDTH-1:0] CONST_ONE      = 9'd1;
    localparam logic [DEF_REGISTER_WIDTH-1:0] CONST_RADIX    = 9'd31;
    localparam logic [DEF_REGISTER_WIDTH-1:0] CONST_I2F_EXP  = 9'd158;
    localparam logic [DEF_REGISTER_WIDTH-1:0] CONST_BIAS     = 9'd127;
    localparam logic [DEF_REGISTER_WIDTH-1:0] CONST_ALL_ONES = 9'd511;

    localparam logic [DEF_NUM_CONST*DEF_REGISTER_WIDTH-1:0] DEF_CONST_TABLE =
        {CONST_ALL_ONES, CONST_BIAS, CONST_I2F_EXP, CONST_RADIX, CONST_ONE, CONST_ZERO};

    function automatic int unsigned const_sel_base(input int unsigned num_gpr);
        return GPR_SEL_BASE + num_gpr;
    endfunction

endpackage

// File: rtl/exp_reg_bank_if.sv
// Dual write / dual read port bundle of the exponent register bank.
interface exp_reg_bank_if #(
    parameter int unsigned REGISTER_WIDTH = 9,
    parameter int unsigned NUM_GPR        = 4,
    parameter int unsigned SEL_WIDTH      = 4
);
    localparam int unsigned ADDR_W = $clog2(NUM_GPR);

    logic                      wrEnA_in;
    logic                      wrEnB_in;
    logic [ADDR_W-1:0]         wrAddrA_in;
    logic [ADDR_W-1:0]         wrAddrB_in;
    logic [REGISTER_WIDTH-1:0] wrDataA_in;
    logic [REGISTER_WIDTH-1:0] wrDataB_in;
    logic [SEL_WIDTH-1:0]      rdSelA_in;
    logic [SEL_WIDTH-1:0]      rdSelB_in;
    logic [REGISTER_WIDTH-1:0] rdResultA_out;
    logic [REGISTER_WIDTH-1:0] rdResultB_out;
    logic                      saveShadow_in;
    logic                      restoreShadow_in;
    logic                      collision_out;
    logic                      badSel_out;

    modport master (
        output wrEnA_in, wrEnB_in, wrAddrA_in, wrAddrB_in, wrDataA_in, wrDataB_in,
        output rdSelA_in, rdSelB_in, saveShadow_in, restoreShadow_in,
        input  rdResultA_out, rdResultB_out, collision_out, badSel_out
    );

    modport slave (
        input  wrEnA_in, wrEnB_in, wrAddrA_in, wrAddrB_in, wrDataA_in, wrDataB_in,
        input  rdSelA_in, rdSelB_in, saveShadow_in, restoreShadow_in,
        output rdResultA_out, rdResultB_out, collision_out, badSel_out
    );

endinterface

// File: rtl/exp_reg_read_port.sv
// One combinational read port: decodes a select into GPR (optionally write-
// forwarded), constant-table entry, or zero with an out-of-range flag.
module exp_reg_read_port
    import exp_reg_bank_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH = DEF_REGISTER_WIDTH,
    parameter int unsigned NUM_GPR        = DEF_NUM_GPR,
    parameter int unsigned NUM_CONST      = DEF_NUM_CONST,
    parameter logic [NUM_CONST*REGISTER_WIDTH-1:0] CONST_TABLE = DEF_CONST_TABLE,
    parameter int unsigned SEL_WIDTH      = DEF_SEL_WIDTH,
    parameter bit          BYPASS         = 1'b1
) (
    input  logic [SEL_WIDTH-1:0]                    sel_i,
    input  logic [NUM_GPR-1:0][REGISTER_WIDTH-1:0]  gpr_i,
    input  logic [NUM_GPR-1:0]                      byp_mask_i,
    input  logic [NUM_GPR-1:0][REGISTER_WIDTH-1:0]  byp_data_i,
    output logic [REGISTER_WIDTH-1:0]               result_o,
    output logic                                    bad_sel_o
);

    always_comb begin
        result_o  = '0;
        bad_sel_o = (32'(sel_i) >= const_sel_base(NUM_GPR) + NUM_CONST);
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            if (32'(sel_i) == GPR_SEL_BASE + i) begin
                result_o = (BYPASS && byp_mask_i[i]) ? byp_data_i[i] : gpr_i[i];
            end
        end
        for (int unsigned j = 0; j < NUM_CONST; j++) begin
            if (32'(sel_i) == const_sel_base(NUM_GPR) + j) begin
                result_o = CONST_TABLE[j*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
    end

endmodule

// File: rtl/exp_reg_bank.sv
// Exponent register bank: dual-write GPRs with a shadow bank for save/restore/
// swap, two combinational read ports and a registered same-address collision flag.
module exp_reg_bank
    import exp_reg_bank_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH = DEF_REGISTER_WIDTH,
    parameter int unsigned NUM_GPR        = DEF_NUM_GPR,
    parameter int unsigned NUM_CONST      = DEF_NUM_CONST,
    parameter logic [NUM_CONST*REGISTER_WIDTH-1:0] CONST_TABLE = DEF_CONST_TABLE,
    parameter int unsigned SEL_WIDTH      = DEF_SEL_WIDTH,
    parameter int unsigned BYPASS         = 1
) (
    input  logic           clk_in,
    input  logic           reset_in,
    exp_reg_bank_if.slave  bus
);

    logic [NUM_GPR-1:0][REGISTER_WIDTH-1:0] gpr_q, gpr_d;
    logic [NUM_GPR-1:0][REGISTER_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_GPR-1:0][REGISTER_WIDTH-1:0] wr_val;
    logic [NUM_GPR-1:0]                     a_hit, b_hit, wr_mask, byp_mask;
    logic                                   collision_q, collision_d;
    logic                                   bad_a, bad_b;

    // Write decode: out-of-range addresses match no GPR and are dropped
    always_comb begin
        a_hit       = '0;
        b_hit       = '0;
        wr_val      = '0;
        gpr_d       = gpr_q;
        shadow_d    = bus.saveShadow_in ? gpr_q : shadow_q;
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            a_hit[i] = bus.wrEnA_in && (32'(bus.wrAddrA_in) == i);
            b_hit[i] = bus.wrEnB_in && (32'(bus.wrAddrB_in) == i);
        end
        wr_mask     = a_hit | b_hit;
        collision_d = |(a_hit & b_hit);
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            wr_val[i] = b_hit[i] ? bus.wrDataB_in : bus.wrDataA_in;
            if (wr_mask[i]) begin
                gpr_d[i] = wr_val[i];
            end else if (bus.restoreShadow_in) begin
                gpr_d[i] = shadow_q[i];
            end
        end
        // Writes are ignored in reset, so nothing is forwarded either
        byp_mask    = reset_in ? '0 : wr_mask;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            gpr_q       <= '0;
            shadow_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            gpr_q       <= gpr_d;
            shadow_q    <= shadow_d;
            collision_q <= collision_d;
        end
    end

    exp_reg_read_port #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .NUM_GPR        (NUM_GPR),
        .NUM_CONST      (NUM_CONST),
        .CONST_TABLE    (CONST_TABLE),
        .SEL_WIDTH      (SEL_WIDTH),
        .BYPASS         (BYPASS != 0)
    ) u_read_a (
        .sel_i      (bus.rdSelA_in),
        .gpr_i      (gpr_q),
        .byp_mask_i (byp_mask),
        .byp_data_i (wr_val),
        .result_o   (bus.rdResultA_out),
        .bad_sel_o  (bad_a)
    );

    exp_reg_read_port #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .NUM_GPR        (NUM_GPR),
        .NUM_CONST      (NUM_CONST),
        .CONST_TABLE    (CONST_TABLE),
        .SEL_WIDTH      (SEL_WIDTH),
        .BYPASS         (BYPASS != 0)
    ) u_read_b (
        .sel_i      (bus.rdSelB_in),
        .gpr_i      (gpr_q),
        .byp_mask_i (byp_mask),
        .byp_data_i (wr_val),
        .result_o   (bus.rdResultB_out),
        .bad_sel_o  (bad_b)
    );

    assign bus.collision_out = collision_q;
    assign bus.badSel_out    = bad_a | bad_b;

endmodule

// File: tb/tb_exp_reg_bank.sv
// Self-checking bench for exp_reg_bank (default parameters, BYPASS=1) using a
// behavioural model and an expected-value queue.
module tb_exp_reg_bank;

    logic clk;
    logic rst;

    exp_reg_bank_if #(.REGISTER_WIDTH(9), .NUM_GPR(4), .SEL_WIDTH(4)) bus_if();

    exp_reg_bank dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      tag;
        int         sig;
        logic [8:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] m_gpr[4];
    logic [8:0] m_sh[4];
    logic       m_coll;
    logic [8:0] const_tbl[6] = '{9'd0, 9'd1, 9'd31, 9'd158, 9'd127, 9'd511};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model_read(input logic [3:0] sel);
        int idx;
        if (sel < 4'd4) begin
            if (!rst && bus_if.wrEnB_in && bus_if.wrAddrB_in == sel[1:0]) return bus_if.wrDataB_in;
            if (!rst && bus_if.wrEnA_in && bus_if.wrAddrA_in == sel[1:0]) return bus_if.wrDataA_in;
            return m_gpr[sel[1:0]];
        end
        if (sel < 4'd10) begin
            idx = int'(sel) - 4;
            return const_tbl[idx];
        end
        return 9'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_gpr[i] = '0;
            m_sh[i]  = '0;
        end
        m_coll = 1'b0;
    endtask

    task automatic model_edge(input logic wa, input logic [1:0] aa, input logic [8:0] da,
                              input logic wb, input logic [1:0] ab, input logic [8:0] db,
                              input logic sv, input logic rs);
        logic [8:0] old_gpr[4];
        old_gpr = m_gpr;
        if (rs) m_gpr = m_sh;
        if (sv) m_sh = old_gpr;
        if (wa) m_gpr[aa] = da;
        if (wb) m_gpr[ab] = db;
        m_coll = wa && wb && (aa == ab);
    endtask

    task automatic push_expected(input string tag);
        exp_t e;
        e.tag = {tag, ".rdA"}; e.sig = 0; e.val = model_read(bus_if.rdSelA_in); exp_q.push_back(e);
        e.tag = {tag, ".rdB"}; e.sig = 1; e.val = model_read(bus_if.rdSelB_in); exp_q.push_back(e);
        e.tag = {tag, ".bad"}; e.sig = 2;
        e.val = 9'((bus_if.rdSelA_in >= 4'd10) || (bus_if.rdSelB_in >= 4'd10));
        exp_q.push_back(e);
        e.tag = {tag, ".coll"}; e.sig = 3; e.val = 9'(m_coll); exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sig)
                0:       got = 32'(bus_if.rdResultA_out);
                1:       got = 32'(bus_if.rdResultB_out);
                2:       got = 32'(bus_if.badSel_out);
                default: got = 32'(bus_if.collision_out);
            endcase
            check_eq(e.tag, got, 32'(e.val));
        end
    endtask

    // One clock: drive at negedge, check pre-edge outputs, advance model at posedge
    task automatic cycle(input string tag,
                         input logic wa, input logic [1:0] aa, input logic [8:0] da,
                         input logic wb, input logic [1:0] ab, input logic [8:0] db,
                         input logic [3:0] sa, input logic [3:0] sb,
                         input logic sv, input logic rs);
        bus_if.wrEnA_in = wa; bus_if.wrAddrA_in = aa; bus_if.wrDataA_in = da;
        bus_if.wrEnB_in = wb; bus_if.wrAddrB_in = ab; bus_if.wrDataB_in = db;
        bus_if.rdSelA_in = sa; bus_if.rdSelB_in = sb;
        bus_if.saveShadow_in = sv; bus_if.restoreShadow_in = rs;
        #1;
        push_expected(tag);
        drain();
        @(posedge clk);
        if (!rst) model_edge(wa, aa, da, wb, ab, db, sv, rs);
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [3:0] sa, input logic [3:0] sb);
        cycle(tag, 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0, sa, sb, 1'b0, 1'b0);
    endtask

    // Direct check against literal values, no clock advance
    task automatic peek(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [8:0] ea, input logic [8:0] eb);
        bus_if.wrEnA_in = 1'b0; bus_if.wrEnB_in = 1'b0;
        bus_if.saveShadow_in = 1'b0; bus_if.restoreShadow_in = 1'b0;
        bus_if.rdSelA_in = sa; bus_if.rdSelB_in = sb;
        #1;
        check_eq({tag, ".A"}, 32'(bus_if.rdResultA_out), 32'(ea));
        check_eq({tag, ".B"}, 32'(bus_if.rdResultB_out), 32'(eb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        model_reset();
        bus_if.wrEnA_in = 1'b0; bus_if.wrAddrA_in = '0; bus_if.wrDataA_in = '0;
        bus_if.wrEnB_in = 1'b0; bus_if.wrAddrB_in = '0; bus_if.wrDataB_in = '0;
        bus_if.rdSelA_in = '0;  bus_if.rdSelB_in = '0;
        bus_if.saveShadow_in = 1'b0; bus_if.restoreShadow_in = 1'b0;
        @(negedge clk);

        // In reset: constants visible, writes/save/restore have no effect
        rd("rst_const", 4'd4, 4'd9);
        cycle("rst_wr", 1'b1, 2'd1, 9'd200, 1'b0, 2'd0, 9'd0, 4'd1, 4'd9, 1'b1, 1'b1);
        rst = 1'b0;
        peek("post_rst", 4'd1, 4'd9, 9'd0, 9'd511);
        rd("sel_bad", 4'd0, 4'd12);
        check_eq("sel12_bad_flag", 32'(bus_if.badSel_out), 32'd1);

        // Bypass on write, then committed value
        cycle("byp", 1'b1, 2'd1, 9'd200, 1'b0, 2'd0, 9'd0, 4'd1, 4'd5, 1'b0, 1'b0);
        peek("byp_next", 4'd1, 4'd1, 9'd200, 9'd200);

        // Same-address dual write: B wins, collision one cycle later only
        cycle("coll", 1'b1, 2'd2, 9'd5, 1'b1, 2'd2, 9'd7, 4'd2, 4'd2, 1'b0, 1'b0);
        rd("coll_d1", 4'd2, 4'd1);
        rd("coll_d2", 4'd2, 4'd3);
        peek("coll_val", 4'd2, 4'd1, 9'd7, 9'd200);

        // Save, overwrite, restore with concurrent write overriding GPR3 only
        cycle("sv_w0", 1'b1, 2'd0, 9'd10, 1'b0, 2'd0, 9'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        cycle("sv", 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0, 4'd0, 4'd3, 1'b1, 1'b0);
        cycle("sv_w20", 1'b1, 2'd0, 9'd20, 1'b0, 2'd0, 9'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        cycle("rs_w3", 1'b1, 2'd3, 9'd99, 1'b0, 2'd0, 9'd0, 4'd0, 4'd3, 1'b0, 1'b1);
        peek("restore", 4'd0, 4'd3, 9'd10, 9'd99);

        // Bank swap and swap back
        cycle("sw_w8", 1'b1, 2'd1, 9'd8, 1'b0, 2'd0, 9'd0, 4'd1, 4'd0, 1'b0, 1'b0);
        cycle("sw_sv", 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0, 4'd1, 4'd0, 1'b1, 1'b0);
        cycle("sw_w3", 1'b0, 2'd0, 9'd0, 1'b1, 2'd1, 9'd3, 4'd1, 4'd0, 1'b0, 1'b0);
        cycle("swap1", 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0, 4'd1, 4'd0, 1'b1, 1'b1);
        peek("swap1_val", 4'd1, 4'd15, 9'd8, 9'd0);
        cycle("swap2", 1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0, 4'd1, 4'd0, 1'b1, 1'b1);
        peek("swap2_val", 4'd1, 4'd8, 9'd3, 9'd127);

        // Mixed random traffic against the model
        for (int n = 0; n < 60; n++) begin
            cycle($sformatf("rnd%0d", n),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 9'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-cycle clears state before the next edge
        cycle("pre_rst", 1'b1, 2'd1, 9'd85, 1'b1, 2'd1, 9'd102, 4'd1, 4'd2, 1'b0, 1'b0);
        check_eq("pre_rst_coll", 32'(bus_if.collision_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_expected("async_rst");
        drain();
        @(negedge clk);
        cycle("in_rst", 1'b1, 2'd2, 9'd44, 1'b0, 2'd0, 9'd0, 4'd2, 4'd1, 1'b1, 1'b0);
        rst = 1'b0;
        cycle("first_edge", 1'b1, 2'd2, 9'd33, 1'b0, 2'd0, 9'd0, 4'd2, 4'd0, 1'b0, 1'b0);
        peek("first_edge_val", 4'd2, 4'd0, 9'd33, 9'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
